// File: rtl/icb_arb_2to1.sv
// Two-master to one-slave ICB arbiter, one transaction outstanding, round-robin on contention.
// Optional response watchdog (TOUT state, error response) enabled by defining ICB_ARB_TIMEOUT_EN.
module icb_arb_2to1 #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_icb_cmd_valid,
  input  logic            m0_icb_cmd_read,
  input  logic [AW-1:0]   m0_icb_cmd_addr,
  input  logic [DW-1:0]   m0_icb_cmd_wdata,
  input  logic [DW/8-1:0] m0_icb_cmd_wmask,
  output logic            m0_icb_cmd_ready,
  output logic            m0_icb_rsp_valid,
  output logic            m0_icb_rsp_err,
  output logic [DW-1:0]   m0_icb_rsp_rdata,
  input  logic            m0_icb_rsp_ready,
  input  logic            m1_icb_cmd_valid,
  input  logic            m1_icb_cmd_read,
  input  logic [AW-1:0]   m1_icb_cmd_addr,
  input  logic [DW-1:0]   m1_icb_cmd_wdata,
  input  logic [DW/8-1:0] m1_icb_cmd_wmask,
  output logic            m1_icb_cmd_ready,
  output logic            m1_icb_rsp_valid,
  output logic            m1_icb_rsp_err,
  output logic [DW-1:0]   m1_icb_rsp_rdata,
  input  logic            m1_icb_rsp_ready,
  output logic            s_icb_cmd_valid,
  output logic            s_icb_cmd_read,
  output logic [AW-1:0]   s_icb_cmd_addr,
  output logic [DW-1:0]   s_icb_cmd_wdata,
  output logic [DW/8-1:0] s_icb_cmd_wmask,
  input  logic            s_icb_cmd_ready,
  input  logic            s_icb_rsp_valid,
  input  logic            s_icb_rsp_err,
  input  logic [DW-1:0]   s_icb_rsp_rdata,
  output logic            s_icb_rsp_ready
);
  localparam int MW = DW / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, RSP = 2'd2, TOUT = 2'd3} state_e;

  if (TIMEOUT_CYC < 1 || DW % 8 != 0) begin : g_bad_cfg
    $error("icb_arb_2to1: TIMEOUT_CYC must be >= 1 and DW a multiple of 8");
  end

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   prio_q, prio_d;
  logic   rst_q;
  logic   quiet;

  logic [1:0]             mv, mrd, mrr;
  logic [1:0][AW-1:0]     maddr;
  logic [1:0][DW-1:0]     mwdata;
  logic [1:0][MW-1:0]     mwmask;
  logic [1:0]             cready, rvalid, rerr;
  logic [1:0][DW-1:0]     rdata;
  logic                   s_cmd_valid_c, s_rsp_ready_c;

`ifdef ICB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  assign mv     = {m1_icb_cmd_valid, m0_icb_cmd_valid};
  assign mrd    = {m1_icb_cmd_read,  m0_icb_cmd_read};
  assign mrr    = {m1_icb_rsp_ready, m0_icb_rsp_ready};
  assign maddr  = {m1_icb_cmd_addr,  m0_icb_cmd_addr};
  assign mwdata = {m1_icb_cmd_wdata, m0_icb_cmd_wdata};
  assign mwmask = {m1_icb_cmd_wmask, m0_icb_cmd_wmask};

  // Outputs are held quiet during reset and for the cycle right after it.
  assign quiet = rst | rst_q;

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

`ifdef ICB_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    prio_d        = prio_q;
    cready        = '0;
    rvalid        = '0;
    rerr          = '0;
    rdata         = '0;
    s_cmd_valid_c = 1'b0;
    s_rsp_ready_c = 1'b0;
`ifdef ICB_ARB_TIMEOUT_EN
    cnt_d         = cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef ICB_ARB_TIMEOUT_EN
        s_rsp_ready_c = 1'b1;  // sink late responses of timed-out transactions
`endif
        if (|mv) begin
          grant_d = (&mv) ? prio_q : mv[1];
          state_d = CMD;
        end
      end
      CMD: begin
        s_cmd_valid_c   = mv[grant_q];
        cready[grant_q] = s_icb_cmd_ready;
        if (mv[grant_q] && s_icb_cmd_ready) begin
          state_d = RSP;
`ifdef ICB_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      RSP: begin
        rvalid[grant_q] = s_icb_rsp_valid;
        rerr[grant_q]   = s_icb_rsp_valid & s_icb_rsp_err;
        rdata[grant_q]  = s_icb_rsp_valid ? s_icb_rsp_rdata : '0;
        s_rsp_ready_c   = mrr[grant_q];
        if (s_icb_rsp_valid && mrr[grant_q]) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
        end
`ifdef ICB_ARB_TIMEOUT_EN
        else if (!s_icb_rsp_valid) begin
          if (cnt_q == CW'(TIMEOUT_CYC - 1)) state_d = TOUT;
          else                               cnt_d   = cnt_q + CW'(1);
        end
`endif
      end
      default: begin
`ifdef ICB_ARB_TIMEOUT_EN
        rvalid[grant_q] = 1'b1;
        rerr[grant_q]   = 1'b1;
        s_rsp_ready_c   = 1'b1;
        if (mrr[grant_q]) begin
          state_d = IDLE;
          prio_d  = ~grant_q;
        end
`else
        state_d = IDLE;
`endif
      end
    endcase
  end

  assign s_icb_cmd_valid  = s_cmd_valid_c & ~quiet;
  assign s_icb_cmd_read   = mrd[grant_q];
  assign s_icb_cmd_addr   = maddr[grant_q];
  assign s_icb_cmd_wdata  = mwdata[grant_q];
  assign s_icb_cmd_wmask  = mwmask[grant_q];
  assign s_icb_rsp_ready  = s_rsp_ready_c & ~quiet;

  assign m0_icb_cmd_ready = cready[0] & ~quiet;
  assign m1_icb_cmd_ready = cready[1] & ~quiet;
  assign m0_icb_rsp_valid = rvalid[0] & ~quiet;
  assign m1_icb_rsp_valid = rvalid[1] & ~quiet;
  assign m0_icb_rsp_err   = rerr[0] & ~quiet;
  assign m1_icb_rsp_err   = rerr[1] & ~quiet;
  assign m0_icb_rsp_rdata = quiet ? '0 : rdata[0];
  assign m1_icb_rsp_rdata = quiet ? '0 : rdata[1];

endmodule
